// File: rtl/cdb_arbiter_if.sv
// Bundle of FU result inputs and CDB broadcast outputs for the CDB arbiter.
// Master is the FU/consumer side; slave is the arbiter itself.
interface cdb_arbiter_if #(
    parameter int FU_COUNT = 8,
    parameter int TAG_W    = 4,
    parameter int DATA_W   = 8,
    parameter int ROB_W    = 8
);
    logic [FU_COUNT-1:0]             fu_valid;
    logic [FU_COUNT-1:0]             fu_ready;
    logic [FU_COUNT-1:0][TAG_W-1:0]  fu_tag;
    logic [FU_COUNT-1:0][DATA_W-1:0] fu_val;
    logic [FU_COUNT-1:0][ROB_W-1:0]  fu_robid;
    logic [FU_COUNT-1:0]             fu_regwrite;
    logic                            cdb_hold;
    logic                            cdbtransmit;
    logic [TAG_W-1:0]                cdbid;
    logic [DATA_W-1:0]               cdbval;
    logic [ROB_W-1:0]                cdb_robid;
    logic                            cdb_regwrite;
    logic [FU_COUNT-1:0]             cdb_grant;

    modport master (
        output fu_valid, fu_tag, fu_val, fu_robid, fu_regwrite, cdb_hold,
        input  fu_ready, cdbtransmit, cdbid, cdbval, cdb_robid, cdb_regwrite, cdb_grant
    );

    modport slave (
        input  fu_valid, fu_tag, fu_val, fu_robid, fu_regwrite, cdb_hold,
        output fu_ready, cdbtransmit, cdbid, cdbval, cdb_robid, cdb_regwrite, cdb_grant
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per FU, round-robin grant of one
// result per cycle onto a registered broadcast.
module cdb_arbiter #(
    parameter int FU_COUNT = 8,
    parameter int TAG_W    = 4,
    parameter int DATA_W   = 8,
    parameter int ROB_W    = 8
) (
    input  logic         clk,
    input  logic         rst,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

    logic [FU_COUNT-1:0] r_full;
    logic [TAG_W-1:0]    r_tag      [FU_COUNT];
    logic [DATA_W-1:0]   r_val      [FU_COUNT];
    logic [ROB_W-1:0]    r_robid    [FU_COUNT];
    logic [FU_COUNT-1:0] r_regwrite;
    logic [PTR_W-1:0]    r_rr_ptr;

    logic                r_cdbtransmit;
    logic [TAG_W-1:0]    r_cdbid;
    logic [DATA_W-1:0]   r_cdbval;
    logic [ROB_W-1:0]    r_cdb_robid;
    logic                r_cdb_regwrite;
    logic [FU_COUNT-1:0] r_cdb_grant;

    logic                w_found;
    logic [PTR_W-1:0]    w_winner;
    int                  w_cand;
    logic                w_grant_en;
    logic [FU_COUNT-1:0] w_grant_vec;
    logic [PTR_W-1:0]    w_rr_next;

    // Requests come only from registered slot state, so ready never depends on inputs.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = 0;
        for (int k = 0; k < FU_COUNT; k++) begin
            w_cand = (int'(r_rr_ptr) + k) % FU_COUNT;
            if (!w_found && r_full[w_cand]) begin
                w_found  = 1'b1;
                w_winner = PTR_W'(w_cand);
            end
        end
    end

    always_comb begin
        w_grant_en  = w_found && !bus.cdb_hold;
        w_grant_vec = '0;
        if (w_grant_en) begin
            w_grant_vec[w_winner] = 1'b1;
        end
        w_rr_next = (w_winner == PTR_W'(FU_COUNT - 1)) ? '0 : w_winner + 1'b1;
    end

    // Grant and accept of the same slot are mutually exclusive since ready = ~full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full     <= '0;
            r_regwrite <= '0;
            for (int i = 0; i < FU_COUNT; i++) begin
                r_tag[i]   <= '0;
                r_val[i]   <= '0;
                r_robid[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FU_COUNT; i++) begin
                if (w_grant_vec[i]) begin
                    r_full[i] <= 1'b0;
                end else if (bus.fu_valid[i] && !r_full[i]) begin
                    r_full[i]     <= 1'b1;
                    r_tag[i]      <= bus.fu_tag[i];
                    r_val[i]      <= bus.fu_val[i];
                    r_robid[i]    <= bus.fu_robid[i];
                    r_regwrite[i] <= bus.fu_regwrite[i];
                end
            end
        end
    end

    // Data outputs hold their last value when nothing is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cdbtransmit  <= 1'b0;
            r_cdb_grant    <= '0;
            r_cdbid        <= '0;
            r_cdbval       <= '0;
            r_cdb_robid    <= '0;
            r_cdb_regwrite <= 1'b0;
            r_rr_ptr       <= '0;
        end else begin
            r_cdbtransmit <= w_grant_en;
            r_cdb_grant   <= w_grant_vec;
            if (w_grant_en) begin
                r_cdbid        <= r_tag[w_winner];
                r_cdbval       <= r_val[w_winner];
                r_cdb_robid    <= r_robid[w_winner];
                r_cdb_regwrite <= r_regwrite[w_winner];
                r_rr_ptr       <= w_rr_next;
            end
        end
    end

    assign bus.fu_ready     = ~r_full;
    assign bus.cdbtransmit  = r_cdbtransmit;
    assign bus.cdbid        = r_cdbid;
    assign bus.cdbval       = r_cdbval;
    assign bus.cdb_robid    = r_cdb_robid;
    assign bus.cdb_regwrite = r_cdb_regwrite;
    assign bus.cdb_grant    = r_cdb_grant;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised and directed checks of cdb_arbiter against a slot/queue-level
// behavioural model of the CDB arbitration rules.
module tb_cdb_arbiter;
    localparam int FU = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.FU_COUNT(FU), .TAG_W(4), .DATA_W(8), .ROB_W(8)) bus ();

    cdb_arbiter #(.FU_COUNT(FU), .TAG_W(4), .DATA_W(8), .ROB_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit         m_full [FU];
    logic [3:0] m_tag  [FU];
    logic [7:0] m_val  [FU];
    logic [7:0] m_rob  [FU];
    bit         m_rw   [FU];
    int         m_rr;
    bit         m_tx;
    logic [7:0] m_grant;
    logic [3:0] m_id;
    logic [7:0] m_v;
    logic [7:0] m_r;
    bit         m_w;

    function automatic logic [7:0] m_ready();
        logic [7:0] r;
        for (int i = 0; i < FU; i++) r[i] = !m_full[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < FU; i++) begin
            m_full[i] = 0; m_tag[i] = 0; m_val[i] = 0; m_rob[i] = 0; m_rw[i] = 0;
        end
        m_rr = 0; m_tx = 0; m_grant = 0; m_id = 0; m_v = 0; m_r = 0; m_w = 0;
    endtask

    // One clock edge of the arbiter, evaluated from the pre-edge model state.
    task automatic model_edge();
        int win;
        win = -1;
        if (!bus.cdb_hold) begin
            for (int k = 0; k < FU; k++) begin
                int idx;
                idx = (m_rr + k) % FU;
                if (win < 0 && m_full[idx]) win = idx;
            end
        end
        m_tx    = (win >= 0);
        m_grant = '0;
        if (win >= 0) begin
            m_grant[win] = 1'b1;
            m_id = m_tag[win]; m_v = m_val[win]; m_r = m_rob[win]; m_w = m_rw[win];
            m_rr = (win + 1) % FU;
        end
        for (int i = 0; i < FU; i++) begin
            if (bus.fu_valid[i] && !m_full[i]) begin
                m_full[i] = 1; m_tag[i] = bus.fu_tag[i]; m_val[i] = bus.fu_val[i];
                m_rob[i] = bus.fu_robid[i]; m_rw[i] = bus.fu_regwrite[i];
            end
        end
        if (win >= 0) m_full[win] = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_idle();
        bus.fu_valid = '0; bus.fu_regwrite = '0; bus.cdb_hold = 1'b0;
        bus.fu_tag = '0; bus.fu_val = '0; bus.fu_robid = '0;
    endtask

    task automatic present(input int s, input logic [3:0] t, input logic [7:0] v,
                           input logic [7:0] r, input bit w);
        bus.fu_valid[s] = 1'b1; bus.fu_tag[s] = t; bus.fu_val[s] = v;
        bus.fu_robid[s] = r; bus.fu_regwrite[s] = w;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #3;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        model_reset();
        #2;
        total++; if (bus.cdbtransmit !== 1'b0) begin bad++; $display("FAIL reset_tx got=%b exp=0", bus.cdbtransmit); end
        total++; if (bus.cdb_grant !== 8'h00) begin bad++; $display("FAIL reset_grant got=%h exp=00", bus.cdb_grant); end
        total++; if ({bus.cdbid, bus.cdbval, bus.cdb_robid, bus.cdb_regwrite} !== 21'd0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h/%b exp=0", bus.cdbid, bus.cdbval, bus.cdb_robid, bus.cdb_regwrite); end
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            total++; if (bus.fu_ready !== 8'hFF) begin bad++; $display("FAIL reset_ready got=%h exp=ff", bus.fu_ready); end
            total++; if (bus.cdbtransmit !== 1'b0) begin bad++; $display("FAIL reset_idle_tx got=%b exp=0", bus.cdbtransmit); end
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        drive_idle();
        present(2, 4'd5, 8'h3C, 8'h11, 1'b1);
        tick();
        drive_idle();
        total++; if (bus.cdbtransmit !== 1'b0) begin bad++; $display("FAIL single_early_tx got=%b exp=0", bus.cdbtransmit); end
        total++; if (bus.fu_ready !== 8'hFB) begin bad++; $display("FAIL single_ready_low got=%h exp=fb", bus.fu_ready); end
        tick();
        total++; if (bus.cdbtransmit !== 1'b1) begin bad++; $display("FAIL single_tx got=%b exp=1", bus.cdbtransmit); end
        total++; if (bus.cdbid !== 4'd5) begin bad++; $display("FAIL single_id got=%h exp=5", bus.cdbid); end
        total++; if (bus.cdbval !== 8'h3C) begin bad++; $display("FAIL single_val got=%h exp=3c", bus.cdbval); end
        total++; if (bus.cdb_robid !== 8'h11) begin bad++; $display("FAIL single_rob got=%h exp=11", bus.cdb_robid); end
        total++; if (bus.cdb_regwrite !== 1'b1) begin bad++; $display("FAIL single_rw got=%b exp=1", bus.cdb_regwrite); end
        total++; if (bus.cdb_grant !== 8'h04) begin bad++; $display("FAIL single_grant got=%h exp=04", bus.cdb_grant); end
        total++; if (bus.fu_ready !== 8'hFF) begin bad++; $display("FAIL single_ready_back got=%h exp=ff", bus.fu_ready); end
        tick();
        total++; if (bus.cdbtransmit !== 1'b0) begin bad++; $display("FAIL single_dup got=%b exp=0", bus.cdbtransmit); end
        total++; if (bus.cdbval !== 8'h3C) begin bad++; $display("FAIL single_retain got=%h exp=3c", bus.cdbval); end
        $display("test_single done");
    endtask

    task automatic test_round_robin();
        int ord [3] = '{0, 3, 7};
        do_reset();
        drive_idle();
        for (int n = 0; n < 3; n++) present(ord[n], 4'(ord[n]), 8'h50 + 8'(ord[n]), 8'hA0 + 8'(ord[n]), 1'b1);
        tick();
        drive_idle();
        for (int n = 0; n < 3; n++) begin
            tick();
            total++; if (bus.cdb_grant !== 8'(1 << ord[n])) begin bad++; $display("FAIL rr_grant%0d got=%h exp=%h", n, bus.cdb_grant, 8'(1 << ord[n])); end
            total++; if (bus.cdb_robid !== 8'hA0 + 8'(ord[n])) begin bad++; $display("FAIL rr_rob%0d got=%h exp=%h", n, bus.cdb_robid, 8'hA0 + 8'(ord[n])); end
        end
        // Slots 0 and 7 together: only a pointer of exactly 0 picks slot 0 first.
        present(0, 4'd1, 8'h01, 8'hB0, 1'b0);
        present(7, 4'd2, 8'h02, 8'hB7, 1'b1);
        tick();
        drive_idle();
        tick();
        total++; if (bus.cdb_grant !== 8'h01) begin bad++; $display("FAIL rr_ptr_zero got=%h exp=01", bus.cdb_grant); end
        total++; if (bus.cdb_regwrite !== 1'b0) begin bad++; $display("FAIL rr_rw got=%b exp=0", bus.cdb_regwrite); end
        tick();
        total++; if (bus.cdb_grant !== 8'h80) begin bad++; $display("FAIL rr_second got=%h exp=80", bus.cdb_grant); end
        tick();
        $display("test_round_robin done");
    endtask

    task automatic test_wrap();
        drive_idle();
        present(5, 4'd3, 8'h33, 8'hC5, 1'b1);
        tick();
        drive_idle();
        tick();
        total++; if (bus.cdb_grant !== 8'h20) begin bad++; $display("FAIL wrap_pre got=%h exp=20", bus.cdb_grant); end
        present(1, 4'd7, 8'h71, 8'hC1, 1'b1);
        present(6, 4'd8, 8'h86, 8'hC6, 1'b0);
        tick();
        drive_idle();
        tick();
        total++; if (bus.cdb_grant !== 8'h40) begin bad++; $display("FAIL wrap_first got=%h exp=40", bus.cdb_grant); end
        tick();
        total++; if (bus.cdb_grant !== 8'h02) begin bad++; $display("FAIL wrap_second got=%h exp=02", bus.cdb_grant); end
        total++; if (bus.cdbval !== 8'h71) begin bad++; $display("FAIL wrap_val got=%h exp=71", bus.cdbval); end
        tick();
        $display("test_wrap done");
    endtask

    task automatic test_backpressure();
        drive_idle();
        bus.cdb_hold = 1'b1;
        present(2, 4'd9, 8'h92, 8'hD2, 1'b1);
        present(5, 4'd10, 8'hA5, 8'hD5, 1'b1);
        tick();
        bus.fu_valid = '0;
        for (int n = 0; n < 4; n++) begin
            tick();
            total++; if (bus.cdbtransmit !== 1'b0) begin bad++; $display("FAIL bp_tx%0d got=%b exp=0", n, bus.cdbtransmit); end
            total++; if ((bus.fu_ready & 8'h24) !== 8'h00) begin bad++; $display("FAIL bp_ready%0d got=%h exp=db", n, bus.fu_ready); end
        end
        bus.cdb_hold = 1'b0;
        for (int n = 0; n < 2; n++) begin
            tick();
            total++; if (bus.cdbtransmit !== 1'b1) begin bad++; $display("FAIL bp_release_tx%0d got=%b exp=1", n, bus.cdbtransmit); end
            total++; if (bus.cdb_grant !== m_grant) begin bad++; $display("FAIL bp_release_grant%0d got=%h exp=%h", n, bus.cdb_grant, m_grant); end
            total++; if (bus.cdb_robid !== m_r) begin bad++; $display("FAIL bp_release_rob%0d got=%h exp=%h", n, bus.cdb_robid, m_r); end
        end
        tick();
        total++; if (bus.cdbtransmit !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0", bus.cdbtransmit); end
        $display("test_backpressure done");
    endtask

    task automatic test_reset_midstream();
        drive_idle();
        bus.cdb_hold = 1'b1;
        present(1, 4'd1, 8'h11, 8'hE1, 1'b1);
        present(4, 4'd4, 8'h44, 8'hE4, 1'b1);
        present(6, 4'd6, 8'h66, 8'hE6, 1'b1);
        tick();
        drive_idle();
        tick();
        total++; if (bus.cdbtransmit !== 1'b1) begin bad++; $display("FAIL mid_inflight got=%b exp=1", bus.cdbtransmit); end
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        total++; if (bus.cdbtransmit !== 1'b0) begin bad++; $display("FAIL mid_async_tx got=%b exp=0", bus.cdbtransmit); end
        total++; if ({bus.cdbid, bus.cdbval, bus.cdb_robid, bus.cdb_regwrite, bus.cdb_grant} !== 29'd0) begin
            bad++; $display("FAIL mid_async_out got=%h/%h/%h/%b/%h exp=0", bus.cdbid, bus.cdbval, bus.cdb_robid, bus.cdb_regwrite, bus.cdb_grant); end
        #2;
        rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            total++; if (bus.cdbtransmit !== 1'b0) begin bad++; $display("FAIL mid_after_tx%0d got=%b exp=0", n, bus.cdbtransmit); end
            total++; if (bus.fu_ready !== 8'hFF) begin bad++; $display("FAIL mid_after_ready%0d got=%h exp=ff", n, bus.fu_ready); end
        end
        $display("test_reset_midstream done");
    endtask

    task automatic test_random();
        drive_idle();
        for (int n = 0; n < 150; n++) begin
            bus.fu_valid    = 8'($urandom) & 8'($urandom);
            bus.fu_regwrite = 8'($urandom);
            bus.cdb_hold    = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < FU; i++) begin
                bus.fu_tag[i] = 4'($urandom); bus.fu_val[i] = 8'($urandom); bus.fu_robid[i] = 8'($urandom);
            end
            tick();
            total++; if (bus.cdbtransmit !== m_tx) begin bad++; $display("FAIL rand_tx c%0d got=%b exp=%b", n, bus.cdbtransmit, m_tx); end
            total++; if (bus.cdb_grant !== m_grant) begin bad++; $display("FAIL rand_grant c%0d got=%h exp=%h", n, bus.cdb_grant, m_grant); end
            total++; if ({bus.cdbid, bus.cdbval, bus.cdb_robid, bus.cdb_regwrite} !== {m_id, m_v, m_r, m_w}) begin
                bad++; $display("FAIL rand_data c%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", n,
                    bus.cdbid, bus.cdbval, bus.cdb_robid, bus.cdb_regwrite, m_id, m_v, m_r, m_w); end
            total++; if (bus.fu_ready !== m_ready()) begin bad++; $display("FAIL rand_ready c%0d got=%h exp=%h", n, bus.fu_ready, m_ready()); end
        end
        drive_idle();
        for (int n = 0; n < FU + 1; n++) tick();
        $display("test_random done");
    endtask

    task automatic test_saturation();
        int         acc_cnt [256];
        int         bc_cnt  [256];
        bit         pend    [FU];
        int         last_acc[FU];
        int         wait_g  [FU];
        logic [7:0] pre_ready;
        logic [7:0] next_rob;
        int         n_acc;
        int         nmis;
        do_reset();
        drive_idle();
        for (int r = 0; r < 256; r++) begin acc_cnt[r] = 0; bc_cnt[r] = 0; end
        for (int i = 0; i < FU; i++) begin pend[i] = 0; last_acc[i] = -10; wait_g[i] = 0; end
        next_rob = 8'h00;
        n_acc = 0;
        for (int n = 0; n < 44; n++) begin
            bus.fu_valid = (n < 32) ? 8'hFF : 8'h00;
            for (int i = 0; i < FU; i++) begin
                if (!pend[i]) begin
                    pend[i] = 1;
                    bus.fu_tag[i] = 4'($urandom); bus.fu_val[i] = 8'($urandom);
                    bus.fu_robid[i] = next_rob; bus.fu_regwrite[i] = 1'($urandom);
                    next_rob++;
                end
            end
            pre_ready = bus.fu_ready;
            total++; if (pre_ready !== m_ready()) begin bad++; $display("FAIL sat_ready c%0d got=%h exp=%h", n, pre_ready, m_ready()); end
            tick();
            for (int i = 0; i < FU; i++) begin
                if (bus.fu_valid[i] && pre_ready[i]) begin
                    pend[i] = 0;
                    acc_cnt[bus.fu_robid[i]]++;
                    n_acc++;
                    total++; if (n - last_acc[i] < 2) begin bad++; $display("FAIL sat_spacing slot%0d got=%0d exp>=2", i, n - last_acc[i]); end
                    last_acc[i] = n;
                    wait_g[i] = 0;
                end
            end
            total++; if (bus.cdb_grant !== m_grant) begin bad++; $display("FAIL sat_grant c%0d got=%h exp=%h", n, bus.cdb_grant, m_grant); end
            if (bus.cdbtransmit === 1'b1) begin
                bc_cnt[bus.cdb_robid]++;
                total++; if (bc_cnt[bus.cdb_robid] !== 1 || acc_cnt[bus.cdb_robid] !== 1) begin
                    bad++; $display("FAIL sat_once rob=%h got=%0d/%0d exp=1/1", bus.cdb_robid, bc_cnt[bus.cdb_robid], acc_cnt[bus.cdb_robid]); end
                total++; if (bus.cdbval !== m_v) begin bad++; $display("FAIL sat_val c%0d got=%h exp=%h", n, bus.cdbval, m_v); end
                for (int i = 0; i < FU; i++) begin
                    if (!pre_ready[i]) begin
                        if (bus.cdb_grant[i]) begin
                            total++; if (wait_g[i] + 1 > FU) begin bad++; $display("FAIL sat_wait slot%0d got=%0d exp<=%0d", i, wait_g[i] + 1, FU); end
                            wait_g[i] = 0;
                        end else begin
                            wait_g[i]++;
                        end
                    end
                end
            end
        end
        nmis = 0;
        for (int r = 0; r < 256; r++) if (acc_cnt[r] != bc_cnt[r]) nmis++;
        total++; if (nmis !== 0) begin bad++; $display("FAIL sat_scoreboard got=%0d exp=0 unmatched", nmis); end
        total++; if (n_acc < 32) begin bad++; $display("FAIL sat_accepts got=%0d exp>=32", n_acc); end
        $display("test_saturation done accepted=%0d", n_acc);
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_reset_midstream();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
